// File: rtl/universal_shift_register_if.sv
// rtl/universal_shift_register_if.sv - control and data bundle for universal_shift_register
interface universal_shift_register_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic             clear;
    logic             shift_enable;
    logic [2:0]       mode;
    logic [WIDTH-1:0] load_data;
    logic             ser_in;
    logic [WIDTH-1:0] data_out;
    logic             ser_out;
    logic [CNT_W-1:0] shift_count;
    logic             word_done;

    modport master (
        output clear, shift_enable, mode, load_data, ser_in,
        input  data_out, ser_out, shift_count, word_done
    );

    modport slave (
        input  clear, shift_enable, mode, load_data, ser_in,
        output data_out, ser_out, shift_count, word_done
    );
endinterface

// File: rtl/universal_shift_register.sv
// rtl/universal_shift_register.sv - shift/rotate/load register with word counter and done pulse
module universal_shift_register #(
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    universal_shift_register_if.slave    bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [2:0] MODE_SHL  = 3'd1;
    localparam logic [2:0] MODE_SHR  = 3'd2;
    localparam logic [2:0] MODE_ROL  = 3'd3;
    localparam logic [2:0] MODE_ROR  = 3'd4;
    localparam logic [2:0] MODE_ASR  = 3'd5;
    localparam logic [2:0] MODE_LOAD = 3'd6;

    logic [WIDTH-1:0] data_q, data_d;
    logic             ser_q, ser_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             counting;

    always_comb begin
        data_d   = data_q;
        ser_d    = ser_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        counting = 1'b0;
        if (bus.shift_enable) begin
            case (bus.mode)
                MODE_SHL: begin
                    data_d   = {data_q[WIDTH-2:0], bus.ser_in};
                    ser_d    = data_q[WIDTH-1];
                    counting = 1'b1;
                end
                MODE_SHR: begin
                    data_d   = {bus.ser_in, data_q[WIDTH-1:1]};
                    ser_d    = data_q[0];
                    counting = 1'b1;
                end
                MODE_ROL: begin
                    data_d   = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                    ser_d    = data_q[WIDTH-1];
                    counting = 1'b1;
                end
                MODE_ROR: begin
                    data_d   = {data_q[0], data_q[WIDTH-1:1]};
                    ser_d    = data_q[0];
                    counting = 1'b1;
                end
                MODE_ASR: begin
                    data_d   = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
                    ser_d    = data_q[0];
                    counting = 1'b1;
                end
                MODE_LOAD: begin
                    data_d = bus.load_data;
                    cnt_d  = '0;
                end
                default: ;
            endcase
        end
        // The counter tracks operations regardless of direction; wrap marks a full word.
        if (counting) begin
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
            ser_q  <= 1'b0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else if (bus.clear) begin
            data_q <= '0;
            ser_q  <= 1'b0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            data_q <= data_d;
            ser_q  <= ser_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign bus.data_out    = data_q;
    assign bus.ser_out     = ser_q;
    assign bus.shift_count = cnt_q;
    assign bus.word_done   = done_q;
endmodule

// File: tb/tb_universal_shift_register.sv
// tb/tb_universal_shift_register.sv - directed and randomized bench against an arithmetic model
module tb_universal_shift_register;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    int m_data, m_ser, m_cnt, m_done;

    universal_shift_register_if #(.WIDTH(8)) bus_if ();

    universal_shift_register #(.WIDTH(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_data = 0; m_ser = 0; m_cnt = 0; m_done = 0;
    endtask

    // Reference: byte arithmetic on an integer, counter as modulo-8 count of shift operations.
    task automatic model_step(input bit clr, input bit en, input int md, input int ld, input int si);
        bit counted = 0;
        if (clr) begin
            model_reset();
            return;
        end
        m_done = 0;
        if (en) begin
            case (md)
                1: begin m_ser = m_data / 128; m_data = (m_data * 2 + si) % 256; counted = 1; end
                2: begin m_ser = m_data % 2; m_data = m_data / 2 + si * 128; counted = 1; end
                3: begin m_ser = m_data / 128; m_data = (m_data * 2) % 256 + m_data / 128; counted = 1; end
                4: begin m_ser = m_data % 2; m_data = m_data / 2 + (m_data % 2) * 128; counted = 1; end
                5: begin m_ser = m_data % 2; m_data = m_data / 2 + ((m_data >= 128) ? 128 : 0); counted = 1; end
                6: begin m_data = ld % 256; m_cnt = 0; end
                default: ;
            endcase
        end
        if (counted) begin
            m_cnt = (m_cnt + 1) % 8;
            m_done = (m_cnt == 0) ? 1 : 0;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".data"},  longint'(bus_if.data_out),    longint'(m_data));
        check({tag, ".ser"},   longint'(bus_if.ser_out),     longint'(m_ser));
        check({tag, ".cnt"},   longint'(bus_if.shift_count), longint'(m_cnt));
        check({tag, ".done"},  longint'(bus_if.word_done),   longint'(m_done));
    endtask

    task automatic cycle(input string tag, input bit clr, input bit en, input int md,
                         input int ld, input int si);
        bus_if.clear        = clr;
        bus_if.shift_enable = en;
        bus_if.mode         = 3'(md);
        bus_if.load_data    = 8'(ld);
        bus_if.ser_in       = si[0];
        @(posedge clk);
        model_step(clr, en, md, ld, si);
        #1;
        compare_all(tag);
    endtask

    initial begin
        bit [7:0] pattern;
        bit [7:0] a5;
        bus_if.clear = 0; bus_if.shift_enable = 0; bus_if.mode = 0;
        bus_if.load_data = 0; bus_if.ser_in = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        compare_all("post_release_idle");

        // Deserialise 1,0,1,1,0,0,1,0 MSB-first
        pattern = 8'b1011_0010;
        for (int i = 0; i < 8; i++) begin
            cycle("deser", 0, 1, 1, 0, int'(pattern[7-i]));
            check("deser.cnt_seq", longint'(bus_if.shift_count), longint'((i + 1) % 8));
            check("deser.done_seq", longint'(bus_if.word_done), (i == 7) ? 1 : 0);
        end
        check("deser.word", longint'(bus_if.data_out), 64'hB2);
        cycle("deser.after", 0, 0, 1, 0, 0);
        check("deser.done_drop", longint'(bus_if.word_done), 0);

        // Serialise A5
        a5 = 8'hA5;
        cycle("ser.load", 0, 1, 6, 'hA5, 0);
        for (int i = 0; i < 8; i++) begin
            cycle("ser.shift", 0, 1, 1, 0, 0);
            check("ser.bit", longint'(bus_if.ser_out), longint'(a5[7-i]));
        end
        check("ser.final", longint'(bus_if.data_out), 0);
        check("ser.done", longint'(bus_if.word_done), 1);

        // Rotate and arithmetic shift
        cycle("rot.load", 0, 1, 6, 'h81, 0);
        cycle("rot.rol", 0, 1, 3, 0, 0);
        check("rol.data", longint'(bus_if.data_out), 64'h03);
        check("rol.ser", longint'(bus_if.ser_out), 1);
        cycle("asr.load", 0, 1, 6, 'h80, 0);
        for (int i = 0; i < 3; i++) cycle("asr", 0, 1, 5, 0, 1);
        check("asr.data", longint'(bus_if.data_out), 64'hF0);
        check("asr.ser", longint'(bus_if.ser_out), 0);

        // Enable gaps mid-word
        cycle("gap.clear", 1, 1, 1, 0, 1);
        for (int i = 0; i < 4; i++) cycle("gap.a", 0, 1, 1, 0, i % 2);
        for (int i = 0; i < 3; i++) cycle("gap.idle", 0, 0, 1, 0, 1);
        for (int i = 0; i < 4; i++) cycle("gap.b", 0, 1, 2, 0, 1);
        check("gap.done", longint'(bus_if.word_done), 1);

        // Mid-word LOAD and clear
        for (int i = 0; i < 5; i++) cycle("abort.shift", 0, 1, 1, 0, 1);
        cycle("abort.load", 0, 1, 6, 'h3C, 0);
        check("abort.cnt", longint'(bus_if.shift_count), 0);
        for (int i = 0; i < 8; i++) begin
            cycle("abort.refill", 0, 1, 1, 0, 0);
            check("abort.done", longint'(bus_if.word_done), (i == 7) ? 1 : 0);
        end
        for (int i = 0; i < 3; i++) cycle("clr.shift", 0, 1, 1, 0, 1);
        cycle("clr.apply", 1, 1, 1, 'hFF, 1);
        check("clr.data", longint'(bus_if.data_out), 0);
        check("clr.cnt", longint'(bus_if.shift_count), 0);

        // Reserved mode
        cycle("rsv.load", 0, 1, 6, 'h5A, 1);
        for (int i = 0; i < 3; i++) cycle("rsv.hold", 0, 1, 7, 'hFF, 1);
        check("rsv.data", longint'(bus_if.data_out), 64'h5A);

        // Asynchronous reset between edges
        for (int i = 0; i < 3; i++) cycle("arst.shift", 0, 1, 1, 0, 1);
        reset_n = 1'b0;
        #2;
        model_reset();
        compare_all("arst.immediate");
        #1 reset_n = 1'b1;
        cycle("arst.first_edge", 0, 0, 1, 0, 1);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            cycle("rand", ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
